axi_rr_arbiter: RTL

// - Shares one AXI manager port (toward memory/interconnect) among NB_MANAGERS CPU managers.
// - Independent round-robin arbitration for the write path (AW/W/B) and the read path (AR/R).
// - One outstanding transaction per path. Responses are routed back to the granted manager.
// - Sits between the cpu instances and the shared AXI subordinate (memory model).

---
 rtl/axi_pkg.sv | 32 +++
 rtl/axi_rr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_pkg.sv
// AXI channel payload types shared by the arbiter, its managers and the subordinate.
package axi_pkg;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
   } axi_aw_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } axi_w_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } axi_b_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
   } axi_ar_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } axi_r_t;

endpackage

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: shares one AXI manager port among NB_MANAGERS managers.
// Independent round-robin write (AW/W/B) and read (AR/R) paths, one
// outstanding transaction each; responses are routed by the registered grant.
// Optional: define AXI_ARB_STATS_EN to add o_grant_count (saturating per-manager
// completed-transaction counters).
module axi_rr_arbiter #(
   parameter int NB_MANAGERS = 4,
   parameter int IDX_W       = $clog2(NB_MANAGERS)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  axi_pkg::axi_aw_t [NB_MANAGERS-1:0]    i_axi_s_aw,
   input  logic             [NB_MANAGERS-1:0]    i_axi_s_awvalid,
   output logic             [NB_MANAGERS-1:0]    o_axi_s_awready,
   input  axi_pkg::axi_w_t  [NB_MANAGERS-1:0]    i_axi_s_w,
   input  logic             [NB_MANAGERS-1:0]    i_axi_s_wvalid,
   output logic             [NB_MANAGERS-1:0]    o_axi_s_wready,
   output axi_pkg::axi_b_t  [NB_MANAGERS-1:0]    o_axi_s_b,
   output logic             [NB_MANAGERS-1:0]    o_axi_s_bvalid,
   input  logic             [NB_MANAGERS-1:0]    i_axi_s_bready,
   input  axi_pkg::axi_ar_t [NB_MANAGERS-1:0]    i_axi_s_ar,
   input  logic             [NB_MANAGERS-1:0]    i_axi_s_arvalid,
   output logic             [NB_MANAGERS-1:0]    o_axi_s_arready,
   output axi_pkg::axi_r_t  [NB_MANAGERS-1:0]    o_axi_s_r,
   output logic             [NB_MANAGERS-1:0]    o_axi_s_rvalid,
   input  logic             [NB_MANAGERS-1:0]    i_axi_s_rready,
   output axi_pkg::axi_aw_t                      o_axi_m_aw,
   output logic                                  o_axi_m_awvalid,
   input  logic                                  i_axi_m_awready,
   output axi_pkg::axi_w_t                       o_axi_m_w,
   output logic                                  o_axi_m_wvalid,
   input  logic                                  i_axi_m_wready,
   input  axi_pkg::axi_b_t                       i_axi_m_b,
   input  logic                                  i_axi_m_bvalid,
   output logic                                  o_axi_m_bready,
   output axi_pkg::axi_ar_t                      o_axi_m_ar,
   output logic                                  o_axi_m_arvalid,
   input  logic                                  i_axi_m_arready,
   input  axi_pkg::axi_r_t                       i_axi_m_r,
   input  logic                                  i_axi_m_rvalid,
   output logic                                  o_axi_m_rready
`ifdef AXI_ARB_STATS_EN
   ,
   output logic [NB_MANAGERS-1:0][31:0]          o_grant_count
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_MANAGERS - 1);

   typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_AR, R_RESP} r_state_e;

   w_state_e         w_state_q;
   r_state_e         r_state_q;
   logic [IDX_W-1:0] w_grant_q, r_grant_q;
   logic [IDX_W-1:0] wr_rr_ptr_q, rd_rr_ptr_q;
   logic             aw_hs, w_hs, b_hs, ar_hs, r_last_hs;

   // First requester at or after ptr, scanning upward with wrap.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NB_MANAGERS-1:0] req,
                                                input logic [IDX_W-1:0]       ptr);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NB_MANAGERS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NB_MANAGERS) idx -= NB_MANAGERS;
         if (!found && req[idx]) begin
            pick  = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
      return (g == LAST_IDX) ? '0 : g + 1'b1;
   endfunction

   assign aw_hs     = (w_state_q == W_AW)   && i_axi_s_awvalid[w_grant_q] && i_axi_m_awready;
   assign w_hs      = (w_state_q == W_DATA) && i_axi_s_wvalid[w_grant_q]  && i_axi_m_wready;
   assign b_hs      = (w_state_q == W_RESP) && i_axi_m_bvalid && i_axi_s_bready[w_grant_q];
   assign ar_hs     = (r_state_q == R_AR)   && i_axi_s_arvalid[r_grant_q] && i_axi_m_arready;
   assign r_last_hs = (r_state_q == R_RESP) && i_axi_m_rvalid && i_axi_s_rready[r_grant_q]
                      && i_axi_m_r.last;

   // Write FSM: arbitrate in idle, then walk AW -> W burst -> B for the grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q   <= W_IDLE;
         w_grant_q   <= '0;
         wr_rr_ptr_q <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: if (|i_axi_s_awvalid) begin
               w_grant_q <= rr_pick(i_axi_s_awvalid, wr_rr_ptr_q);
               w_state_q <= W_AW;
            end
            W_AW:   if (aw_hs) w_state_q <= W_DATA;
            W_DATA: if (w_hs && i_axi_s_w[w_grant_q].last) w_state_q <= W_RESP;
            W_RESP: if (b_hs) begin
               w_state_q   <= W_IDLE;
               wr_rr_ptr_q <= next_ptr(w_grant_q);
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   // Read FSM: arbitrate in idle, then AR -> R burst until the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q   <= R_IDLE;
         r_grant_q   <= '0;
         rd_rr_ptr_q <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: if (|i_axi_s_arvalid) begin
               r_grant_q <= rr_pick(i_axi_s_arvalid, rd_rr_ptr_q);
               r_state_q <= R_AR;
            end
            R_AR:   if (ar_hs) r_state_q <= R_RESP;
            R_RESP: if (r_last_hs) begin
               r_state_q   <= R_IDLE;
               rd_rr_ptr_q <= next_ptr(r_grant_q);
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   // Write-path routing: only the active channel of the granted manager is connected.
   always_comb begin
      o_axi_m_aw      = '0;
      o_axi_m_awvalid = 1'b0;
      o_axi_s_awready = '0;
      o_axi_m_w       = '0;
      o_axi_m_wvalid  = 1'b0;
      o_axi_s_wready  = '0;
      o_axi_s_b       = '0;
      o_axi_s_bvalid  = '0;
      o_axi_m_bready  = 1'b0;
      case (w_state_q)
         W_AW: begin
            o_axi_m_aw                 = i_axi_s_aw[w_grant_q];
            o_axi_m_awvalid            = i_axi_s_awvalid[w_grant_q];
            o_axi_s_awready[w_grant_q] = i_axi_m_awready;
         end
         W_DATA: begin
            o_axi_m_w                 = i_axi_s_w[w_grant_q];
            o_axi_m_wvalid            = i_axi_s_wvalid[w_grant_q];
            o_axi_s_wready[w_grant_q] = i_axi_m_wready;
         end
         W_RESP: begin
            o_axi_s_b[w_grant_q]      = i_axi_m_b;
            o_axi_s_bvalid[w_grant_q] = i_axi_m_bvalid;
            o_axi_m_bready            = i_axi_s_bready[w_grant_q];
         end
         default: ;
      endcase
   end

   // Read-path routing, same scheme as the write path.
   always_comb begin
      o_axi_m_ar      = '0;
      o_axi_m_arvalid = 1'b0;
      o_axi_s_arready = '0;
      o_axi_s_r       = '0;
      o_axi_s_rvalid  = '0;
      o_axi_m_rready  = 1'b0;
      case (r_state_q)
         R_AR: begin
            o_axi_m_ar                 = i_axi_s_ar[r_grant_q];
            o_axi_m_arvalid            = i_axi_s_arvalid[r_grant_q];
            o_axi_s_arready[r_grant_q] = i_axi_m_arready;
         end
         R_RESP: begin
            o_axi_s_r[r_grant_q]      = i_axi_m_r;
            o_axi_s_rvalid[r_grant_q] = i_axi_m_rvalid;
            o_axi_m_rready            = i_axi_s_rready[r_grant_q];
         end
         default: ;
      endcase
   end

`ifdef AXI_ARB_STATS_EN
   logic [NB_MANAGERS-1:0][31:0] cnt_q, cnt_d;
   logic [NB_MANAGERS-1:0][1:0]  cnt_inc;
   logic [NB_MANAGERS-1:0][32:0] cnt_sum;

   // Per-manager completion count; a write and read finishing together add 2.
   always_comb begin
      for (int i = 0; i < NB_MANAGERS; i++) begin
         cnt_inc[i] = {1'b0, b_hs && (w_grant_q == IDX_W'(i))}
                    + {1'b0, r_last_hs && (r_grant_q == IDX_W'(i))};
         cnt_sum[i] = {1'b0, cnt_q[i]} + {31'b0, cnt_inc[i]};
         cnt_d[i]   = cnt_sum[i][32] ? '1 : cnt_sum[i][31:0];
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign o_grant_count = cnt_q;
`endif

endmodule
